// File: rtl/trigger_unit_pkg.sv
// Shared state encoding and default widths for the multi-channel trigger unit.
package trigger_unit_pkg;

  localparam int NUM_TRIG_MAX = 8;
  localparam int DEF_NUM_TRIG = 4;
  localparam int DEF_OFFSET_W = 32;
  localparam int DEF_SEG_W    = 16;
  localparam int DEF_LEN_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED_PEND,
    ST_WAIT_INACT,
    ST_ARMED,
    ST_DELAY,
    ST_REARM,
    ST_DONE_WAIT
  } state_t;

endpackage

// File: rtl/cdc_simple.sv
// Two-flop synchroniser for a single asynchronous level into the local clock domain.
module cdc_simple (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/trigger_unit_mc.sv
// Multi-channel, multi-segment trigger unit: channel combine, offset delay, one capture_go_o per segment.
// Optional post-capture holdoff is built when TRIGGER_UNIT_HOLDOFF_EN is defined (adds port holdoff_i).
module trigger_unit_mc
  import trigger_unit_pkg::*;
#(
  parameter int NUM_TRIG = DEF_NUM_TRIG,
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int SEG_W    = DEF_SEG_W,
  parameter int LEN_W    = DEF_LEN_W
) (
  input  logic                adc_clk,
  input  logic                reset_n,
  input  logic [NUM_TRIG-1:0] trigger_i,
  input  logic [NUM_TRIG-1:0] trig_enable_i,
  input  logic [NUM_TRIG-1:0] trig_level_i,
  input  logic                trig_and_i,
  input  logic                trigger_wait_i,
  input  logic                trigger_now_i,
  input  logic                arm_i,
  input  logic                armed_and_ready_i,
  input  logic [OFFSET_W-1:0] trigger_offset_i,
  input  logic [SEG_W-1:0]    num_segments_i,
  input  logic                capture_done_i,
`ifdef TRIGGER_UNIT_HOLDOFF_EN
  input  logic [15:0]         holdoff_i,
`endif
  output logic                arm_o,
  output logic                capture_active_o,
  output logic                capture_go_o,
  output logic [SEG_W-1:0]    segment_count_o,
  output logic [NUM_TRIG-1:0] trig_source_o,
  output logic [LEN_W-1:0]    trigger_length_o,
  output state_t              dbg_state
);

  // Handshake: armed_and_ready_i is a level sampled only while arming; capture_done_i is a level
  // that ends the run from any non-idle state; capture_go_o is a one-cycle strobe, no back-pressure.

  state_t              state, state_nxt;
  logic [NUM_TRIG-1:0] chan_hit;
  logic                match_raw, match, hold_busy;
  logic                now_sync, now_d, now_rise, arm_d, arm_rise;
  logic [OFFSET_W-1:0] cnt;
  logic                rearm_seen;
  logic [SEG_W-1:0]    segs_eff;
  logic                last_seg;
  logic                clear_run, start_delay, first_trig, fire, cnt_inc, rearm_set;

  assign chan_hit  = trig_enable_i & ~(trigger_i ^ trig_level_i);
  assign match_raw = trig_and_i ? ((trig_enable_i != '0) && ((chan_hit | ~trig_enable_i) == '1))
                                : (chan_hit != '0);
  assign match     = match_raw & ~hold_busy;

  cdc_simple u_now_sync (
    .clk  (adc_clk),
    .rst_n(reset_n),
    .d    (trigger_now_i),
    .q    (now_sync)
  );

  assign now_rise = now_sync & ~now_d;
  assign arm_rise = arm_i & ~arm_d;
  assign segs_eff = (num_segments_i == '0) ? SEG_W'(1) : num_segments_i;
  assign last_seg = ({1'b0, segment_count_o} + (SEG_W+1)'(1)) >= {1'b0, segs_eff};

`ifdef TRIGGER_UNIT_HOLDOFF_EN
  logic [15:0] hold_cnt;

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n)               hold_cnt <= '0;
    else if (clear_run)         hold_cnt <= '0;
    else if (fire)              hold_cnt <= holdoff_i;
    else if (hold_cnt != '0)    hold_cnt <= hold_cnt - 16'd1;
  end

  assign hold_busy = (hold_cnt != '0);
`else
  assign hold_busy = 1'b0;
`endif

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    clear_run   = 1'b0;
    start_delay = 1'b0;
    first_trig  = 1'b0;
    fire        = 1'b0;
    cnt_inc     = 1'b0;
    rearm_set   = 1'b0;
    case (state)
      ST_IDLE: if (arm_rise) begin
        clear_run = 1'b1;
        state_nxt = trigger_wait_i ? ST_WAIT_INACT : ST_ARMED_PEND;
      end
      ST_ARMED_PEND: if (armed_and_ready_i) state_nxt = ST_ARMED;
      ST_WAIT_INACT: if (armed_and_ready_i && !match) state_nxt = ST_ARMED;
      ST_ARMED: if (match || now_rise) begin
        state_nxt   = ST_DELAY;
        start_delay = 1'b1;
        first_trig  = 1'b1;
      end
      ST_DELAY: if (cnt == trigger_offset_i) begin
        fire      = 1'b1;
        state_nxt = last_seg ? ST_DONE_WAIT : ST_REARM;
      end else begin
        cnt_inc = 1'b1;
      end
      // A new segment needs the combined match to go inactive and then active again.
      ST_REARM: if (rearm_seen && match) begin
        state_nxt   = ST_DELAY;
        start_delay = 1'b1;
      end else if (!match && !hold_busy) begin
        rearm_set = 1'b1;
      end
      ST_DONE_WAIT: state_nxt = ST_DONE_WAIT;
      default: state_nxt = ST_IDLE;
    endcase
    // Abort wins over everything, including a go due on the same edge.
    if (state != ST_IDLE && (capture_done_i || !arm_i)) begin
      state_nxt   = ST_IDLE;
      start_delay = 1'b0;
      first_trig  = 1'b0;
      fire        = 1'b0;
      cnt_inc     = 1'b0;
      rearm_set   = 1'b0;
    end
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      now_d            <= 1'b0;
      arm_d            <= 1'b0;
      cnt              <= '0;
      rearm_seen       <= 1'b0;
      capture_go_o     <= 1'b0;
      segment_count_o  <= '0;
      trig_source_o    <= '0;
      trigger_length_o <= '0;
    end else begin
      now_d        <= now_sync;
      arm_d        <= arm_i;
      capture_go_o <= fire;
      if (start_delay)  cnt <= '0;
      else if (cnt_inc) cnt <= cnt + OFFSET_W'(1);
      if (start_delay || fire) rearm_seen <= 1'b0;
      else if (rearm_set)      rearm_seen <= 1'b1;
      if (clear_run)                                   segment_count_o <= '0;
      else if (fire && segment_count_o != '1)          segment_count_o <= segment_count_o + SEG_W'(1);
      if (clear_run)       trig_source_o <= '0;
      else if (first_trig) trig_source_o <= chan_hit;
      if (clear_run) trigger_length_o <= '0;
      else if (state != ST_IDLE && match_raw && trigger_length_o != '1)
        trigger_length_o <= trigger_length_o + LEN_W'(1);
    end
  end

  assign arm_o            = (state == ST_WAIT_INACT) || (state == ST_ARMED);
  assign capture_active_o = (state == ST_DELAY) || (state == ST_REARM) || (state == ST_DONE_WAIT);
  assign dbg_state        = state;

endmodule
